dmi_jtag_dr: RTL and testbench

- Data-register stage directly downstream of the debug TAP controller.
- Owns the RISC-V debug `dtmcs` (32-bit) and `dmi` (ABITS+34-bit) shift registers, and drives each serial TDO back to the TAP.
- On Update-DR of `dmi`, issues one request to the debug module over a valid/ready request/response handshake.
- Runs entirely in the TCK domain; any CDC to the core clock lives in a separate block.

---
 rtl/dmi_jtag_dr.sv | 159 +++++++++++++++
 tb/tb_dmi_jtag_dr.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_dr.sv
// JTAG data-register stage for the RISC-V debug transport: owns the dtmcs and dmi
// shift registers and turns a dmi Update-DR into one valid/ready request to the DM.
module dmi_jtag_dr #(
    parameter int ABITS     = 7,
    parameter int IDLE_HINT = 1,
    parameter int VERSION   = 1
) (
    input  logic             tck_i,
    input  logic             rst_i,
    input  logic             tdi_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             dtmcs_select_i,
    input  logic             dmi_select_i,
    input  logic             dmi_clear_i,
    output logic             dtmcs_tdo_o,
    output logic             dmi_tdo_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [ABITS-1:0] dmi_req_addr_o,
    output logic [31:0]      dmi_req_data_o,
    output logic [1:0]       dmi_req_op_o,
    input  logic             dmi_resp_valid_i,
    output logic             dmi_resp_ready_o,
    input  logic [31:0]      dmi_resp_data_i,
    input  logic [1:0]       dmi_resp_op_i
);

    localparam int DW = ABITS + 34;

    localparam logic [2:0] IDLE_F    = 3'(IDLE_HINT);
    localparam logic [5:0] ABITS_F   = 6'(ABITS);
    localparam logic [3:0] VERSION_F = 4'(VERSION);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        dtmcs_sr;
    logic [DW-1:0]      dmi_sr;
    logic [ABITS-1:0]   addr_q;
    logic [31:0]        data_q;
    logic [1:0]         op_q;
    logic [1:0]         err;
    logic [1:0]         cap_op;
    logic               req_valid_q;
    logic               resp_ready_q;

    logic [1:0]         upd_op;
    logic [31:0]        upd_data;
    logic [ABITS-1:0]   upd_addr;

    assign dtmcs_tdo_o      = dtmcs_sr[0];
    assign dmi_tdo_o        = dmi_sr[0];
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = op_q;

    assign upd_op   = dmi_sr[1:0];
    assign upd_data = dmi_sr[33:2];
    assign upd_addr = dmi_sr[DW-1:34];

    always_comb begin
        cap_op = err;
        if (state != IDLE) cap_op = 2'd3;
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state        <= IDLE;
            dtmcs_sr     <= '0;
            dmi_sr       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            op_q         <= '0;
            err          <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
        end else if (dmi_clear_i) begin
            state        <= IDLE;
            dtmcs_sr     <= '0;
            dmi_sr       <= '0;
            err          <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
        end else begin
            if (dtmcs_select_i) begin
                if (capture_i)
                    dtmcs_sr <= {14'b0, 1'b0, 1'b0, 1'b0, IDLE_F, err, ABITS_F, VERSION_F};
                else if (shift_i)
                    dtmcs_sr <= {tdi_i, dtmcs_sr[31:1]};
            end

            if (dmi_select_i) begin
                if (capture_i) begin
                    dmi_sr <= {addr_q, data_q, cap_op};
                    if (state != IDLE && err == 2'd0) err <= 2'd3;
                end else if (shift_i) begin
                    dmi_sr <= {tdi_i, dmi_sr[DW-1:1]};
                end
            end

            unique case (state)
                IDLE: begin
                    resp_ready_q <= 1'b1;
                    req_valid_q  <= 1'b0;
                end
                REQ: begin
                    if (dmi_req_ready_i) begin
                        state        <= RESP;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (dmi_resp_valid_i) begin
                        data_q       <= dmi_resp_data_i;
                        state        <= IDLE;
                        resp_ready_q <= 1'b1;
                        if (dmi_resp_op_i != 2'd0 && err == 2'd0) err <= 2'd2;
                    end
                end
                default: state <= IDLE;
            endcase

            // Later assignments intentionally override the FSM defaults above.
            if (update_i && dmi_select_i && err == 2'd0) begin
                if (state != IDLE) begin
                    err <= 2'd3;
                end else if (upd_op == 2'd1 || upd_op == 2'd2) begin
                    addr_q       <= upd_addr;
                    data_q       <= upd_data;
                    op_q         <= upd_op;
                    state        <= REQ;
                    req_valid_q  <= 1'b1;
                    resp_ready_q <= 1'b0;
                end
            end

            if (update_i && dtmcs_select_i) begin
                if (dtmcs_sr[17]) begin
                    state        <= IDLE;
                    req_valid_q  <= 1'b0;
                    resp_ready_q <= 1'b1;
                    err          <= '0;
                end else if (dtmcs_sr[16]) begin
                    err <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: drives TAP scans and a hand-modelled debug module.
module tb_dmi_jtag_dr;

    logic        tck = 1'b0;
    logic        rst = 1'b1;
    logic        tdi = 1'b0;
    logic        capture = 1'b0;
    logic        shift = 1'b0;
    logic        update = 1'b0;
    logic        dtmcs_sel = 1'b0;
    logic        dmi_sel = 1'b0;
    logic        dmi_clear = 1'b0;
    logic        dtmcs_tdo;
    logic        dmi_tdo;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_data = '0;
    logic [1:0]  resp_op = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] dt_out;
    logic [40:0] dm_out;

    always #5 tck = ~tck;

    dmi_jtag_dr #(.ABITS(7), .IDLE_HINT(1), .VERSION(1)) dut (
        .tck_i(tck), .rst_i(rst), .tdi_i(tdi),
        .capture_i(capture), .shift_i(shift), .update_i(update),
        .dtmcs_select_i(dtmcs_sel), .dmi_select_i(dmi_sel), .dmi_clear_i(dmi_clear),
        .dtmcs_tdo_o(dtmcs_tdo), .dmi_tdo_o(dmi_tdo),
        .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
        .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
        .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
        .dmi_resp_data_i(resp_data), .dmi_resp_op_i(resp_op)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge tck);
        #1;
    endtask

    task automatic scan_dtmcs(input logic [31:0] din, output logic [31:0] dout);
        dtmcs_sel = 1'b1; capture = 1'b1;
        cycle();
        capture = 1'b0; shift = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tdi = din[i];
            dout[i] = dtmcs_tdo;
            cycle();
        end
        shift = 1'b0; tdi = 1'b0; update = 1'b1;
        cycle();
        update = 1'b0; dtmcs_sel = 1'b0;
    endtask

    task automatic scan_dmi(input logic [40:0] din, output logic [40:0] dout);
        dmi_sel = 1'b1; capture = 1'b1;
        cycle();
        capture = 1'b0; shift = 1'b1;
        for (int i = 0; i < 41; i++) begin
            tdi = din[i];
            dout[i] = dmi_tdo;
            cycle();
        end
        shift = 1'b0; tdi = 1'b0; update = 1'b1;
        cycle();
        update = 1'b0; dmi_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        checks++; if (dtmcs_tdo !== 1'b0) begin errors++; $display("FAIL reset_dtmcs_tdo got=%b exp=0", dtmcs_tdo); end
        checks++; if (dmi_tdo !== 1'b0) begin errors++; $display("FAIL reset_dmi_tdo got=%b exp=0", dmi_tdo); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got=%b exp=0", resp_ready); end
        rst = 1'b0;
        cycle();
        checks++; if (resp_ready !== 1'b1) begin errors++; $display("FAIL idle_resp_ready got=%b exp=1", resp_ready); end
    endtask

    task automatic test_dtmcs_capture();
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1071) begin errors++; $display("FAIL dtmcs_capture got=%h exp=00001071", dt_out); end
    endtask

    task automatic test_write();
        scan_dmi({7'h10, 32'h0000_0001, 2'd2}, dm_out);
        checks++; if (dm_out !== 41'h0) begin errors++; $display("FAIL write_capture got=%h exp=0", dm_out); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 7'h10 || req_data !== 32'h1 || req_op !== 2'd2 || resp_ready !== 1'b0) begin
                errors++;
                $display("FAIL write_req_hold c=%0d got v=%b a=%h d=%h op=%0d rr=%b exp v=1 a=10 d=1 op=2 rr=0",
                         c, req_valid, req_addr, req_data, req_op, resp_ready);
            end
            if (c == 2) req_ready = 1'b1;
            cycle();
        end
        req_ready = 1'b0;
        checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin errors++; $display("FAIL write_resp_state got v=%b rr=%b exp v=0 rr=1", req_valid, resp_ready); end
        resp_valid = 1'b1; resp_data = 32'h1234_5678; resp_op = 2'd0;
        cycle();
        resp_valid = 1'b0;
        scan_dmi(41'h0, dm_out);
        checks++; if (dm_out !== {7'h10, 32'h1234_5678, 2'd0}) begin errors++; $display("FAIL write_after_resp got=%h exp=%h", dm_out, {7'h10, 32'h1234_5678, 2'd0}); end
    endtask

    task automatic test_read();
        scan_dmi({7'h11, 32'h0, 2'd1}, dm_out);
        checks++; if (req_valid !== 1'b1 || req_addr !== 7'h11 || req_op !== 2'd1) begin errors++; $display("FAIL read_req got v=%b a=%h op=%0d exp v=1 a=11 op=1", req_valid, req_addr, req_op); end
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF; resp_op = 2'd0;
        cycle();
        resp_valid = 1'b0;
        checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin errors++; $display("FAIL read_idle got v=%b rr=%b exp v=0 rr=1", req_valid, resp_ready); end
        scan_dmi(41'h0, dm_out);
        checks++; if (dm_out !== {7'h11, 32'hDEAD_BEEF, 2'd0}) begin errors++; $display("FAIL read_data got=%h exp=%h", dm_out, {7'h11, 32'hDEAD_BEEF, 2'd0}); end
    endtask

    task automatic test_busy();
        scan_dmi({7'h05, 32'hAAAA_5555, 2'd2}, dm_out);
        scan_dmi({7'h06, 32'h0000_0001, 2'd2}, dm_out);
        checks++; if (dm_out !== {7'h05, 32'hAAAA_5555, 2'd3}) begin errors++; $display("FAIL busy_capture got=%h exp=%h", dm_out, {7'h05, 32'hAAAA_5555, 2'd3}); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 7'h05 || req_data !== 32'hAAAA_5555) begin errors++; $display("FAIL busy_req_kept got v=%b a=%h d=%h exp v=1 a=05 d=aaaa5555", req_valid, req_addr, req_data); end
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1C71) begin errors++; $display("FAIL busy_dmistat got=%h exp=00001c71", dt_out); end
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0; resp_op = 2'd0;
        cycle();
        resp_valid = 1'b0;
        scan_dtmcs(32'h0001_0000, dt_out);
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1071) begin errors++; $display("FAIL dmireset_clears got=%h exp=00001071", dt_out); end
        scan_dmi({7'h07, 32'h0, 2'd1}, dm_out);
        checks++; if (req_valid !== 1'b1 || req_addr !== 7'h07) begin errors++; $display("FAIL busy_next_req got v=%b a=%h exp v=1 a=07", req_valid, req_addr); end
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0BAD_F00D;
        cycle();
        resp_valid = 1'b0;
    endtask

    task automatic test_resp_error();
        scan_dmi({7'h08, 32'h0, 2'd1}, dm_out);
        req_ready = 1'b1;
        cycle();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hCAFE_F00D; resp_op = 2'd2;
        cycle();
        resp_valid = 1'b0; resp_op = 2'd0;
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1871) begin errors++; $display("FAIL err_dmistat got=%h exp=00001871", dt_out); end
        scan_dmi({7'h09, 32'h0, 2'd2}, dm_out);
        checks++; if (dm_out !== {7'h08, 32'hCAFE_F00D, 2'd2}) begin errors++; $display("FAIL err_capture got=%h exp=%h", dm_out, {7'h08, 32'hCAFE_F00D, 2'd2}); end
        cycle();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL err_req_ignored got=%b exp=0", req_valid); end
        scan_dtmcs(32'h0001_0000, dt_out);
        scan_dmi({7'h09, 32'h5, 2'd2}, dm_out);
        checks++; if (dm_out !== {7'h08, 32'hCAFE_F00D, 2'd0}) begin errors++; $display("FAIL err_cleared_capture got=%h exp=%h", dm_out, {7'h08, 32'hCAFE_F00D, 2'd0}); end
        checks++; if (req_valid !== 1'b1 || req_addr !== 7'h09 || req_data !== 32'h5 || req_op !== 2'd2) begin errors++; $display("FAIL err_cleared_req got v=%b a=%h d=%h op=%0d exp v=1 a=09 d=5 op=2", req_valid, req_addr, req_data, req_op); end
    endtask

    task automatic test_clear();
        dmi_clear = 1'b1;
        cycle();
        dmi_clear = 1'b0;
        checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b1 || dmi_tdo !== 1'b0) begin errors++; $display("FAIL clear_outputs got v=%b rr=%b tdo=%b exp v=0 rr=1 tdo=0", req_valid, resp_ready, dmi_tdo); end
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1071) begin errors++; $display("FAIL clear_dtmcs got=%h exp=00001071", dt_out); end
        scan_dmi({7'h0A, 32'h7, 2'd2}, dm_out);
        checks++; if (dm_out !== {7'h09, 32'h5, 2'd0}) begin errors++; $display("FAIL clear_keeps_addr_data got=%h exp=%h", dm_out, {7'h09, 32'h5, 2'd0}); end
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL hard_pre_req got=%b exp=1", req_valid); end
        scan_dtmcs(32'h0002_0000, dt_out);
        checks++; if (req_valid !== 1'b0 || resp_ready !== 1'b1) begin errors++; $display("FAIL hardreset_outputs got v=%b rr=%b exp v=0 rr=1", req_valid, resp_ready); end
        scan_dmi(41'h0, dm_out);
        checks++; if (dm_out !== {7'h0A, 32'h7, 2'd0}) begin errors++; $display("FAIL hardreset_capture got=%h exp=%h", dm_out, {7'h0A, 32'h7, 2'd0}); end
    endtask

    task automatic test_reset_mid_shift();
        scan_dmi({7'h0B, 32'h3, 2'd1}, dm_out);
        dmi_sel = 1'b1; capture = 1'b1;
        cycle();
        capture = 1'b0; shift = 1'b1; tdi = 1'b1;
        cycle(); cycle();
        checks++; if (dmi_tdo !== 1'b1 || req_valid !== 1'b1) begin errors++; $display("FAIL pre_rst got tdo=%b v=%b exp tdo=1 v=1", dmi_tdo, req_valid); end
        rst = 1'b1;
        cycle();
        checks++; if (dmi_tdo !== 1'b0 || dtmcs_tdo !== 1'b0 || req_valid !== 1'b0 || resp_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_shift got dmi_tdo=%b dtmcs_tdo=%b v=%b rr=%b exp all 0", dmi_tdo, dtmcs_tdo, req_valid, resp_ready);
        end
        rst = 1'b0; shift = 1'b0; tdi = 1'b0; dmi_sel = 1'b0;
        cycle();
        scan_dtmcs(32'h0, dt_out);
        checks++; if (dt_out !== 32'h0000_1071) begin errors++; $display("FAIL rst_err_cleared got=%h exp=00001071", dt_out); end
        scan_dmi(41'h0, dm_out);
        checks++; if (dm_out !== 41'h0) begin errors++; $display("FAIL rst_regs_cleared got=%h exp=0", dm_out); end
    endtask

    initial begin
        test_reset();
        test_dtmcs_capture();
        test_write();
        test_read();
        test_busy();
        test_resp_error();
        test_clear();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
